// File: rtl/proc_pkg.sv
// Shared processor definitions: opcode constants, instruction/imem widths
// and the program loader state encoding.
package proc_pkg;

    localparam int INSTR_W = 16;
    localparam int IMEM_AW = 8;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_LOAD = 4'b1000;
    localparam logic [3:0] OP_INC  = 4'b1010;
    localparam logic [3:0] OP_DEC  = 4'b1011;
    localparam logic [3:0] OP_HLT  = 4'b1100;
    localparam logic [3:0] OP_DJNZ = 4'b1110;
    localparam logic [3:0] OP_JMP  = 4'b1111;

    typedef enum logic [2:0] {
        LDR_IDLE  = 3'd0,
        LDR_COUNT = 3'd1,
        LDR_HI    = 3'd2,
        LDR_LO    = 3'd3,
        LDR_WRITE = 3'd4,
        LDR_CSUM  = 3'd5,
        LDR_DONE  = 3'd6
    } ldr_state_t;

    // States in which the loader takes a byte from the stream.
    function automatic logic ldr_takes_byte(ldr_state_t s);
        return (s == LDR_COUNT) || (s == LDR_HI) || (s == LDR_LO) || (s == LDR_CSUM);
    endfunction

endpackage

// File: rtl/ldr_timeout_cnt.sv
// Inter-byte idle timer for the program loader. Down-counter reloaded on
// clear; expire asserts on the TIMEOUT_CYC-th consecutive enabled cycle
// without a clear. TIMEOUT_CYC = 0 disables expiry entirely.
module ldr_timeout_cnt #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LOAD = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

    logic [CW-1:0] cnt;

    // Reload on clear, otherwise count down to terminal count and hold there.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= LOAD;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expire = (TIMEOUT_CYC != 0) && enable && (cnt == '0);

endmodule

// File: rtl/prog_loader.sv
// Program loader: assembles a count-prefixed big-endian byte stream into
// 16-bit instruction words, writes them to consecutive imem addresses and
// holds the CPU until a complete image has been accepted.
// Optional macro LOADER_CHECKSUM_EN: frame ends with an XOR checksum byte
// over all bytes after the count byte; a mismatch aborts the load.
//
// state | meaning
// IDLE  | waiting for start; CPU held (also the state after an abort)
// COUNT | taking the word-count byte (0 means 256 words)
// HI    | taking the upper byte of the next word
// LO    | taking the lower byte of the next word
// WRITE | one-cycle imem write of {hi,lo}; no byte taken
// CSUM  | taking the trailing checksum byte (checksum build only)
// DONE  | image loaded, CPU released until the next start
module prog_loader
    import proc_pkg::*;
#(
    parameter int                ADDR_W      = IMEM_AW,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               s_valid,
    input  logic [7:0]         s_data,
    output logic               s_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               err,
    output logic [8:0]         words_loaded
);

    ldr_state_t        state, state_nx;
    logic [8:0]        count_n;
    logic [7:0]        hi_byte, lo_byte;
    logic [ADDR_W-1:0] ptr;
    logic [8:0]        words;
    logic              err_r;
    logic              xfer;
    logic              arm;
    logic              fail;
    logic              last_word;
    logic              timer_en;
    logic              timer_clr;
    logic              expire;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign s_ready   = ldr_takes_byte(state);
    assign xfer      = s_valid && s_ready;
    assign arm       = start && ((state == LDR_IDLE) || (state == LDR_DONE));
    assign last_word = ((words + 9'd1) == count_n);
    assign timer_en  = s_ready;
    assign timer_clr = xfer || !timer_en;

    ldr_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clr),
        .enable (timer_en),
        .expire (expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LDR_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; fail flags any abort path (timeout or bad checksum).
    always_comb begin
        state_nx = state;
        fail     = 1'b0;
        case (state)
            LDR_IDLE: begin
                if (arm) state_nx = LDR_COUNT;
            end
            LDR_COUNT: begin
                if (xfer) begin
                    state_nx = LDR_HI;
                end else if (expire) begin
                    state_nx = LDR_IDLE;
                    fail     = 1'b1;
                end
            end
            LDR_HI: begin
                if (xfer) begin
                    state_nx = LDR_LO;
                end else if (expire) begin
                    state_nx = LDR_IDLE;
                    fail     = 1'b1;
                end
            end
            LDR_LO: begin
                if (xfer) begin
                    state_nx = LDR_WRITE;
                end else if (expire) begin
                    state_nx = LDR_IDLE;
                    fail     = 1'b1;
                end
            end
            LDR_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
                state_nx = last_word ? LDR_CSUM : LDR_HI;
`else
                state_nx = last_word ? LDR_DONE : LDR_HI;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            LDR_CSUM: begin
                if (xfer) begin
                    if (s_data == csum) begin
                        state_nx = LDR_DONE;
                    end else begin
                        state_nx = LDR_IDLE;
                        fail     = 1'b1;
                    end
                end else if (expire) begin
                    state_nx = LDR_IDLE;
                    fail     = 1'b1;
                end
            end
`endif
            LDR_DONE: begin
                if (arm) state_nx = LDR_COUNT;
            end
            default: state_nx = LDR_IDLE;
        endcase
    end

    // Datapath: frame bookkeeping, byte capture, write pointer and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_n <= '0;
            hi_byte <= '0;
            lo_byte <= '0;
            ptr     <= BASE_ADDR;
            words   <= '0;
            err_r   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum    <= '0;
`endif
        end else begin
            if (arm) begin
                ptr   <= BASE_ADDR;
                words <= '0;
                err_r <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                csum  <= '0;
`endif
            end
            if (fail) begin
                err_r <= 1'b1;
            end
            if (xfer) begin
                case (state)
                    LDR_COUNT: count_n <= (s_data == 8'd0) ? 9'd256 : {1'b0, s_data};
                    LDR_HI:    hi_byte <= s_data;
                    LDR_LO:    lo_byte <= s_data;
                    default:   ;
                endcase
`ifdef LOADER_CHECKSUM_EN
                if ((state == LDR_HI) || (state == LDR_LO)) begin
                    csum <= csum ^ s_data;
                end
`endif
            end
            if (state == LDR_WRITE) begin
                ptr   <= ptr + ADDR_W'(1);
                words <= words + 9'd1;
            end
        end
    end

    assign imem_we      = (state == LDR_WRITE);
    assign imem_addr    = ptr;
    assign imem_wdata   = {hi_byte, lo_byte};
    assign cpu_hold     = (state != LDR_DONE);
    assign done         = (state == LDR_DONE);
    assign err          = err_r;
    assign words_loaded = words;

endmodule
